// File: rtl/spi_pkg.sv
// Shared types for the SPI register memory arbiter: default widths, FSM state,
// requester identity and the captured SPI command record.
package spi_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef enum logic {REQ_SPI, REQ_HOST} req_t;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Bundle of the SPI command path, host port and memory port seen by the arbiter.
// slave: the arbiter's view; master: the surrounding logic (SPI, host, memory).
interface spi_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) ();

   logic              spi_write;
   logic              spi_read;
   logic [ADDR_W-1:0] spi_address;
   logic [DATA_W-1:0] spi_wdata;
   logic [DATA_W-1:0] spi_rdata;
   logic              spi_rvalid;
   logic              spi_busy;
   logic              spi_overrun;
   logic              spi_overrun_clr;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;

   logic              mem_write;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  spi_write, spi_read, spi_address, spi_wdata, spi_overrun_clr,
      input  host_req, host_we, host_addr, host_wdata,
      input  mem_data_out,
      output spi_rdata, spi_rvalid, spi_busy, spi_overrun,
      output host_ack, host_rdata,
      output mem_write, mem_read, mem_address, mem_data_in
   );

   modport master (
      output spi_write, spi_read, spi_address, spi_wdata, spi_overrun_clr,
      output host_req, host_we, host_addr, host_wdata,
      output mem_data_out,
      input  spi_rdata, spi_rvalid, spi_busy, spi_overrun,
      input  host_ack, host_rdata,
      input  mem_write, mem_read, mem_address, mem_data_in
   );

endinterface

// File: rtl/spi_req_capture.sv
// Single-entry holding slot for SPI read/write pulses plus the sticky overrun flag.
// The slot frees when the arbiter takes it, and may refill in that same cycle.
module spi_req_capture
   import spi_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_write,
   input  logic                  spi_read,
   input  logic [DEF_ADDR_W-1:0] spi_address,
   input  logic [DEF_DATA_W-1:0] spi_wdata,
   input  logic                  take,
   input  logic                  overrun_clr,
   output logic                  busy,
   output cmd_t                  cmd,
   output logic                  overrun
);

   logic pulse;
   logic slot_free;

   // A pulse can land if the slot is empty now or is being handed to the arbiter.
   always_comb begin
      pulse     = spi_write | spi_read;
      slot_free = ~busy | take;
   end

   // Slot fill/drain and overrun tracking; a read+write collision counts as a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         cmd     <= '0;
         overrun <= 1'b0;
      end else begin
         if (pulse && slot_free) begin
            busy      <= 1'b1;
            cmd.we    <= spi_write;
            cmd.addr  <= spi_address;
            cmd.wdata <= spi_wdata;
         end else if (take) begin
            busy <= 1'b0;
         end
         // A new overrun beats a same-cycle clear.
         if ((pulse && !slot_free) || (spi_write && spi_read)) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing the single-port SPI register memory between the
// captured SPI command and the host port. Each access runs IDLE -> ISSUE ->
// [WAIT x MEM_RD_LAT for reads] -> RESP -> IDLE. Widths follow spi_pkg defaults.
module spi_mem_arbiter
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned MEM_RD_LAT = 1  // 1..3
) (
   input logic              clk,
   input logic              rst,
   spi_mem_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

   state_t            state_q;
   req_t              last_grant_q;
   req_t              side_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              mem_write_q;
   logic              mem_read_q;
   logic              host_ack_q;
   logic              spi_rvalid_q;
   logic [DATA_W-1:0] host_rdata_q;
   logic [DATA_W-1:0] spi_rdata_q;

   logic              cap_busy;
   cmd_t              cap_cmd;
   logic              cap_overrun;

   logic              grant_spi;
   logic              grant_host;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   spi_req_capture u_capture (
      .clk         (clk),
      .rst         (rst),
      .spi_write   (bus.spi_write),
      .spi_read    (bus.spi_read),
      .spi_address (bus.spi_address),
      .spi_wdata   (bus.spi_wdata),
      .take        (grant_spi),
      .overrun_clr (bus.spi_overrun_clr),
      .busy        (cap_busy),
      .cmd         (cap_cmd),
      .overrun     (cap_overrun)
   );

   // Grant in IDLE only; on a tie the side that did not win last time goes.
   always_comb begin
      grant_spi  = 1'b0;
      grant_host = 1'b0;
      if (state_q == IDLE) begin
         if (cap_busy && bus.host_req) begin
            grant_spi  = (last_grant_q == REQ_HOST);
            grant_host = (last_grant_q == REQ_SPI);
         end else begin
            grant_spi  = cap_busy;
            grant_host = bus.host_req;
         end
      end
   end

   // Command of the winning requester, latched on the grant.
   always_comb begin
      sel_we    = grant_spi ? cap_cmd.we    : bus.host_we;
      sel_addr  = grant_spi ? cap_cmd.addr  : bus.host_addr;
      sel_wdata = grant_spi ? cap_cmd.wdata : bus.host_wdata;
   end

   // Access sequencer with registered strobes, address/data and responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_HOST;
         side_q       <= REQ_SPI;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         host_ack_q   <= 1'b0;
         spi_rvalid_q <= 1'b0;
         host_rdata_q <= '0;
         spi_rdata_q  <= '0;
      end else begin
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         host_ack_q   <= 1'b0;
         spi_rvalid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant_spi || grant_host) begin
                  state_q      <= ISSUE;
                  side_q       <= grant_spi ? REQ_SPI : REQ_HOST;
                  last_grant_q <= grant_spi ? REQ_SPI : REQ_HOST;
                  we_q         <= sel_we;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
                  mem_write_q  <= sel_we;
                  mem_read_q   <= ~sel_we;
               end
            end
            ISSUE: begin
               cnt_q <= '0;
               if (we_q) begin
                  state_q    <= RESP;
                  host_ack_q <= (side_q == REQ_HOST);
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= RESP;
                  if (side_q == REQ_HOST) begin
                     host_ack_q   <= 1'b1;
                     host_rdata_q <= bus.mem_data_out;
                  end else begin
                     spi_rvalid_q <= 1'b1;
                     spi_rdata_q  <= bus.mem_data_out;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               addr_q  <= '0;
               wdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_write   = mem_write_q;
   assign bus.mem_read    = mem_read_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.host_ack    = host_ack_q;
   assign bus.host_rdata  = host_rdata_q;
   assign bus.spi_rvalid  = spi_rvalid_q;
   assign bus.spi_rdata   = spi_rdata_q;
   assign bus.spi_busy    = cap_busy;
   assign bus.spi_overrun = cap_overrun;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Randomized bench for spi_mem_arbiter. The reference model works per transaction:
// grants are scheduled from the round-robin rule and fixed latencies, memory
// contents come from a plain array, and the SPI slot/overrun follow the capture rules.
module tb_spi_mem_arbiter;

   localparam int unsigned LAT = 1;

   logic clk = 1'b0;
   logic rst;

   spi_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   spi_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .MEM_RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: read data valid only LAT cycles after the strobe, junk otherwise.
   logic [7:0] tb_mem  [16]  = '{default: 8'h00};
   logic [7:0] rd_data [LAT] = '{default: 8'h00};
   logic       rd_vld  [LAT] = '{default: 1'b0};
   logic [7:0] junk          = 8'h5c;

   always @(posedge clk) begin
      junk <= 8'($urandom);
      if (bus.mem_write) tb_mem[bus.mem_address] <= bus.mem_data_in;
      rd_vld[0]  <= bus.mem_read;
      rd_data[0] <= tb_mem[bus.mem_address];
      for (int i = 1; i < int'(LAT); i++) begin
         rd_vld[i]  <= rd_vld[i-1];
         rd_data[i] <= rd_data[i-1];
      end
   end

   assign bus.mem_data_out = rd_vld[LAT-1] ? rd_data[LAT-1] : junk;

   // Reference model state
   int         cyc       = 0;
   int         n_chk     = 0;
   int         n_fail    = 0;
   bit         m_slot_v  = 0;
   bit         m_slot_we = 0;
   logic [3:0] m_slot_a  = '0;
   logic [7:0] m_slot_d  = '0;
   bit         m_ovr     = 0;
   bit         m_last_host = 1;
   int         m_free_at = 0;
   logic [7:0] ref_mem [16] = '{default: 8'h00};
   logic [7:0] e_hrd = '0;
   logic [7:0] e_srd = '0;
   // Transaction in flight (granted at t_T, response at t_resp)
   bit         t_v = 0;
   int         t_T = 0;
   int         t_resp = 0;
   bit         t_host = 0;
   bit         t_we = 0;
   logic [3:0] t_a = '0;
   logic [7:0] t_d = '0;
   logic [7:0] t_rd = '0;
   // Host driver
   bit         h_act = 0;
   bit         h_we = 0;
   logic [3:0] h_a = '0;
   logic [7:0] h_d = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic zero_inputs();
      bus.spi_write       = 1'b0;
      bus.spi_read        = 1'b0;
      bus.spi_address     = '0;
      bus.spi_wdata       = '0;
      bus.spi_overrun_clr = 1'b0;
      bus.host_req        = 1'b0;
      bus.host_we         = 1'b0;
      bus.host_addr       = '0;
      bus.host_wdata      = '0;
   endtask

   task automatic model_reset();
      m_slot_v    = 0;
      m_ovr       = 0;
      m_last_host = 1;
      m_free_at   = cyc;
      t_v         = 0;
      e_hrd       = '0;
      e_srd       = '0;
      h_act       = 0;
   endtask

   task automatic check_outputs();
      bit in_t;
      bit at_resp;
      in_t    = t_v && (cyc > t_T) && (cyc <= t_resp);
      at_resp = t_v && (cyc == t_resp);
      if (at_resp && !t_we) begin
         if (t_host) e_hrd = t_rd;
         else        e_srd = t_rd;
      end
      check_eq("mem_write",   32'(bus.mem_write),   32'(in_t && cyc == t_T + 1 && t_we));
      check_eq("mem_read",    32'(bus.mem_read),    32'(in_t && cyc == t_T + 1 && !t_we));
      check_eq("mem_address", 32'(bus.mem_address), in_t ? 32'(t_a) : 32'd0);
      check_eq("mem_data_in", 32'(bus.mem_data_in), in_t ? 32'(t_d) : 32'd0);
      check_eq("host_ack",    32'(bus.host_ack),    32'(at_resp && t_host));
      check_eq("spi_rvalid",  32'(bus.spi_rvalid),  32'(at_resp && !t_host && !t_we));
      check_eq("host_rdata",  32'(bus.host_rdata),  32'(e_hrd));
      check_eq("spi_rdata",   32'(bus.spi_rdata),   32'(e_srd));
      check_eq("spi_busy",    32'(bus.spi_busy),    32'(m_slot_v));
      check_eq("spi_overrun", 32'(bus.spi_overrun), 32'(m_ovr));
   endtask

   // Advance the model by one cycle using the inputs driven for this cycle.
   task automatic model_step();
      bit g_spi;
      bit g_host;
      bit pulse;
      bit free;
      g_spi  = 0;
      g_host = 0;
      if (cyc >= m_free_at) begin
         if (m_slot_v && bus.host_req) begin
            g_spi  = m_last_host;
            g_host = !m_last_host;
         end else begin
            g_spi  = m_slot_v;
            g_host = bus.host_req;
         end
         if (g_spi || g_host) begin
            t_v       = 1;
            t_T       = cyc;
            t_host    = g_host;
            t_we      = g_spi ? m_slot_we : bus.host_we;
            t_a       = g_spi ? m_slot_a  : bus.host_addr;
            t_d       = g_spi ? m_slot_d  : bus.host_wdata;
            t_resp    = cyc + 2 + (t_we ? 0 : int'(LAT));
            m_free_at = t_resp + 1;
            if (t_we) ref_mem[t_a] = t_d;
            else      t_rd = ref_mem[t_a];
            m_last_host = g_host;
         end
      end
      pulse = bus.spi_write || bus.spi_read;
      free  = !m_slot_v || g_spi;
      if (pulse && free) begin
         m_slot_v  = 1;
         m_slot_we = bus.spi_write;
         m_slot_a  = bus.spi_address;
         m_slot_d  = bus.spi_wdata;
      end else if (g_spi) begin
         m_slot_v = 0;
      end
      if ((pulse && !free) || (bus.spi_write && bus.spi_read)) m_ovr = 1;
      else if (bus.spi_overrun_clr) m_ovr = 0;
   endtask

   // Percent probabilities for a new host request, an SPI pulse, a double pulse, a clear.
   task automatic drive_inputs(input int p_host, input int p_spi, input int p_both,
                               input int p_clr);
      if (t_v && t_host && cyc == t_resp) begin
         h_act = 0;
      end else if (!h_act && int'($urandom_range(0, 99)) < p_host) begin
         h_act = 1;
         h_we  = 1'($urandom);
         h_a   = 4'($urandom);
         h_d   = 8'($urandom);
      end
      bus.host_req   = h_act;
      bus.host_we    = h_we;
      bus.host_addr  = h_a;
      bus.host_wdata = h_d;
      bus.spi_address = 4'($urandom);
      bus.spi_wdata   = 8'($urandom);
      if (int'($urandom_range(0, 99)) < p_spi) begin
         if (int'($urandom_range(0, 99)) < p_both) begin
            bus.spi_write = 1'b1;
            bus.spi_read  = 1'b1;
         end else begin
            bus.spi_write = 1'($urandom);
            bus.spi_read  = !bus.spi_write;
         end
      end else begin
         bus.spi_write = 1'b0;
         bus.spi_read  = 1'b0;
      end
      bus.spi_overrun_clr = (int'($urandom_range(0, 99)) < p_clr);
   endtask

   // Reset while a read sits in WAIT: everything idles and the access is lost.
   task automatic mid_reset();
      rst = 1'b1;
      zero_inputs();
      #1;
      check_eq("rst_host_ack", 32'(bus.host_ack), 32'd0);
      check_eq("rst_mem_read", 32'(bus.mem_read), 32'd0);
      check_eq("rst_mem_addr", 32'(bus.mem_address), 32'd0);
      check_eq("rst_spi_busy", 32'(bus.spi_busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      cyc += 2;
      rst = 1'b0;
      model_reset();
      check_outputs();
   endtask

   task automatic run_cycles(input int n, input int p_host, input int p_spi, input int p_both,
                             input int p_clr, input bit allow_rst);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_outputs();
         if (allow_rst && t_v && !t_we && cyc == t_T + 2 && $urandom_range(0, 3) == 0) begin
            mid_reset();
         end
         drive_inputs(p_host, p_spi, p_both, p_clr);
         model_step();
      end
   endtask

   initial begin
      // Requests held active through reset must not reach the memory.
      zero_inputs();
      rst             = 1'b1;
      bus.host_req    = 1'b1;
      bus.host_we     = 1'b1;
      bus.host_addr   = 4'd5;
      bus.spi_write   = 1'b1;
      bus.spi_address = 4'd2;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst0_mem_write",  32'(bus.mem_write),   32'd0);
      check_eq("rst0_mem_read",   32'(bus.mem_read),    32'd0);
      check_eq("rst0_host_ack",   32'(bus.host_ack),    32'd0);
      check_eq("rst0_spi_busy",   32'(bus.spi_busy),    32'd0);
      check_eq("rst0_spi_ovr",    32'(bus.spi_overrun), 32'd0);
      check_eq("rst0_mem_addr",   32'(bus.mem_address), 32'd0);
      zero_inputs();
      rst = 1'b0;
      cyc = 0;
      model_reset();
      check_outputs();
      model_step();

      // Host write 3 <= A5, then read it back.
      h_act = 1; h_we = 1; h_a = 4'd3; h_d = 8'hA5;
      run_cycles(5, 0, 0, 0, 0, 0);
      h_act = 1; h_we = 0; h_a = 4'd3; h_d = 8'h00;
      run_cycles(6, 0, 0, 0, 0, 0);
      check_eq("host_rd_a5", 32'(bus.host_rdata), 32'hA5);

      run_cycles(300, 30, 20, 0, 0, 0);    // light traffic
      run_cycles(500, 100, 70, 5, 3, 1);   // both sides saturated, overruns, resets
      run_cycles(500, 50, 40, 15, 10, 1);  // mixed with frequent read+write collisions
      run_cycles(30, 0, 0, 0, 100, 0);     // drain and clear overrun
      check_eq("final_ovr_clr", 32'(bus.spi_overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
